// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// ----------------------------------------------------------------------------
// VGA timing and image-window address generator. A clock divider produces a
// one-clk pixel enable. Horizontal and vertical counters run across the
// regions active, front porch, sync and back porch. An image window of
// IMG_W x IMG_H buffer pixels, optionally shown 2x2, is placed at
// (IMG_X0, IMG_Y0) and clipped at the edge of the active area. Row and column
// read addresses are issued into the frame buffer for that window. Sync, active
// and window flags are delayed so that they line up with the returning
// ram_pixel data.
//
// Optional build macro:
//   VGA_BORDER_EN  active-area pixels outside the image window are shown as
//                  grey 12'h444 instead of black.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   scale2x      1 = each buffer pixel shown as 2x2 (sampled at frame start)
//   ram_pixel    frame-buffer data, RAM_LAT pixel ticks after the address
//   row_read     buffer row address (0 outside the window)
//   col_read     buffer column address (0 outside the window)
//   vga_hs/vs    sync outputs, active level SYNC_POL
//   vga_r/g/b    RGB444 colour
//   frame_start  one-clk pulse on the pixel tick where hc=0, vc=0
//   pix_ce       pixel enable, high for one clk every CLK_DIV clks
// ----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int IMG_W    = 320,
    parameter int IMG_H    = 240,
    parameter int IMG_X0   = 0,
    parameter int IMG_Y0   = 0,
    parameter int RAM_LAT  = 1,
    parameter int PIX_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scale2x,
    input  logic [PIX_W-1:0] ram_pixel,
    output logic [7:0]       row_read,
    output logic [8:0]       col_read,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [3:0]       vga_r,
    output logic [3:0]       vga_g,
    output logic [3:0]       vga_b,
    output logic             frame_start,
    output logic             pix_ce
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic SYNC_ON = (SYNC_POL != 0);

    // ------------------------------------------------------------------
    // Pixel-enable divider. The run flag keeps pix_ce low on the first clk
    // after reset so that CLK_DIV=1 still shows pix_ce=0 while in reset.
    // ------------------------------------------------------------------
    logic [DW-1:0] div_cnt;
    logic          run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            run     <= 1'b0;
        end else begin
            run <= 1'b1;
            if (div_cnt == DW'(CLK_DIV - 1)) div_cnt <= '0;
            else                             div_cnt <= div_cnt + DW'(1);
        end
    end

    assign pix_ce = run && (div_cnt == DW'(CLK_DIV - 1));

    // ------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------
    logic [HW-1:0] hc;
    logic [VW-1:0] vc;
    logic          at_origin;

    assign at_origin = (hc == '0) && (vc == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc <= '0;
            vc <= '0;
        end else if (pix_ce) begin
            if (hc == HW'(H_TOTAL - 1)) begin
                hc <= '0;
                if (vc == VW'(V_TOTAL - 1)) vc <= '0;
                else                        vc <= vc + VW'(1);
            end else begin
                hc <= hc + HW'(1);
            end
        end
    end

    assign frame_start = pix_ce && at_origin;

    // ------------------------------------------------------------------
    // Scale mode: latched once per frame. The origin pixel itself already
    // belongs to the new frame, so it uses the live input directly.
    // ------------------------------------------------------------------
    logic mode_q;
    logic mode_eff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           mode_q <= 1'b0;
        else if (frame_start) mode_q <= scale2x;
    end

    assign mode_eff = at_origin ? scale2x : mode_q;

    // ------------------------------------------------------------------
    // Region decode and window test. Offsets are computed unsigned, so a
    // pixel left of / above the origin wraps to a huge value and fails the
    // size compare without a separate lower-bound test.
    // ------------------------------------------------------------------
    logic [31:0] x_off, y_off, win_w, win_h;
    logic        active, in_win, hs_on, vs_on;
    logic [8:0]  col_addr;
    logic [7:0]  row_addr;

    always_comb begin
        x_off    = 32'(hc) - 32'(IMG_X0);
        y_off    = 32'(vc) - 32'(IMG_Y0);
        win_w    = mode_eff ? 32'(2 * IMG_W) : 32'(IMG_W);
        win_h    = mode_eff ? 32'(2 * IMG_H) : 32'(IMG_H);
        active   = (32'(hc) < 32'(H_ACTIVE)) && (32'(vc) < 32'(V_ACTIVE));
        in_win   = active && (x_off < win_w) && (y_off < win_h);
        hs_on    = (32'(hc) >= 32'(H_ACTIVE + H_FP)) &&
                   (32'(hc) <  32'(H_ACTIVE + H_FP + H_SYNC));
        vs_on    = (32'(vc) >= 32'(V_ACTIVE + V_FP)) &&
                   (32'(vc) <  32'(V_ACTIVE + V_FP + V_SYNC));
        col_addr = mode_eff ? x_off[9:1] : x_off[8:0];
        row_addr = mode_eff ? y_off[8:1] : y_off[7:0];
    end

    // ------------------------------------------------------------------
    // Address register plus delay line for {hs, vs, active, in_win}.
    // Stage RAM_LAT is valid in the same tick as the matching ram_pixel.
    // ------------------------------------------------------------------
    logic [3:0] dly [RAM_LAT+1];
    logic [3:0] tap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_read <= '0;
            col_read <= '0;
            for (int i = 0; i <= RAM_LAT; i++) dly[i] <= '0;
        end else if (pix_ce) begin
            row_read <= in_win ? row_addr : 8'd0;
            col_read <= in_win ? col_addr : 9'd0;
            dly[0]   <= {hs_on, vs_on, active, in_win};
            for (int i = 1; i <= RAM_LAT; i++) dly[i] <= dly[i-1];
        end
    end

    assign tap = dly[RAM_LAT];

    // ------------------------------------------------------------------
    // Output register
    // ------------------------------------------------------------------
    logic [PIX_W-1:0] color_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_hs  <= ~SYNC_ON;
            vga_vs  <= ~SYNC_ON;
            color_q <= '0;
        end else if (pix_ce) begin
            vga_hs <= tap[3] ? SYNC_ON : ~SYNC_ON;
            vga_vs <= tap[2] ? SYNC_ON : ~SYNC_ON;
            if (!tap[1])     color_q <= '0;
            else if (tap[0]) color_q <= ram_pixel;
`ifdef VGA_BORDER_EN
            else             color_q <= PIX_W'(12'h444);
`else
            else             color_q <= '0;
`endif
        end
    end

    assign vga_r = color_q[PIX_W-1 -: 4];
    assign vga_g = color_q[PIX_W-5 -: 4];
    assign vga_b = color_q[PIX_W-9 -: 4];

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
// ----------------------------------------------------------------------------
// Bench for vga_timing_gen using a shrunken raster so several frames fit in a
// short run. The reference model works from the absolute pixel-tick number:
// pixel position, frame number and per-frame scale mode are derived with
// plain arithmetic, and outputs are expected a fixed number of ticks later.
// The frame buffer is modelled as ram_pixel = {row[3:0], col[7:0]} returned
// RAM_LAT ticks after the address.
// ----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int D   = 2;
    localparam int HA  = 16, HF = 2, HS = 3, HB = 3;
    localparam int VA  = 10, VF = 1, VS = 2, VB = 2;
    localparam int HT  = HA + HF + HS + HB;
    localparam int VT  = VA + VF + VS + VB;
    localparam int FT  = HT * VT;
    localparam int W   = 5, H = 3, X0 = 8, Y0 = 5;
    localparam int L   = 2;
    localparam logic SYNC_ON = 1'b0;
`ifdef VGA_BORDER_EN
    localparam logic [11:0] OUT_COL = 12'h444;
`else
    localparam logic [11:0] OUT_COL = 12'h000;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        scale2x;
    logic [11:0] ram_pixel;
    logic [7:0]  row_read;
    logic [8:0]  col_read;
    logic        vga_hs, vga_vs, frame_start, pix_ce;
    logic [3:0]  vga_r, vga_g, vga_b;

    vga_timing_gen #(
        .CLK_DIV(D), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0),
        .IMG_W(W), .IMG_H(H), .IMG_X0(X0), .IMG_Y0(Y0), .RAM_LAT(L), .PIX_W(12)
    ) dut (
        .clk(clk), .rst_n(rst_n), .scale2x(scale2x), .ram_pixel(ram_pixel),
        .row_read(row_read), .col_read(col_read), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start), .pix_ce(pix_ce)
    );

    // ---------------- frame-buffer model ----------------
    logic [11:0] ram_pipe [L];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < L; i++) ram_pipe[i] <= '0;
        end else if (pix_ce) begin
            ram_pipe[0] <= {row_read[3:0], col_read[7:0]};
            for (int i = 1; i < L; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign ram_pixel = ram_pipe[L-1];

    // ---------------- reference time base ----------------
    // e_cnt: clk edges since reset release; c_cnt: pixel ticks completed.
    int   e_cnt, c_cnt;
    logic exp_pce;
    logic mode_by_frame [256];

    always_comb exp_pce = (e_cnt >= 1) && ((e_cnt % D) == D - 1);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt <= 0;
            c_cnt <= 0;
        end else begin
            e_cnt <= e_cnt + 1;
            if (exp_pce) begin
                c_cnt <= c_cnt + 1;
                if (c_cnt % FT == 0) mode_by_frame[(c_cnt / FT) % 256] <= scale2x;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic bit model_in_win(int t);
        int x, y, s;
        if (t < 0) return 1'b0;
        x = t % HT;
        y = (t / HT) % VT;
        s = mode_by_frame[(t / FT) % 256] ? 2 : 1;
        return (x < HA) && (y < VA) && (x >= X0) && (y >= Y0) &&
               (x - X0 < W * s) && (y - Y0 < H * s);
    endfunction

    function automatic logic [16:0] exp_addr(int t);
        int x, y, s;
        if (!model_in_win(t)) return 17'd0;
        x = t % HT;
        y = (t / HT) % VT;
        s = mode_by_frame[(t / FT) % 256] ? 2 : 1;
        return {8'((y - Y0) / s), 9'((x - X0) / s)};
    endfunction

    function automatic logic [11:0] exp_colour(int t);
        logic [16:0] a;
        int x, y;
        if (t < 0) return 12'h000;
        x = t % HT;
        y = (t / HT) % VT;
        if (!((x < HA) && (y < VA))) return 12'h000;
        if (!model_in_win(t)) return OUT_COL;
        a = exp_addr(t);
        return {a[12:9], a[7:0]};
    endfunction

    function automatic logic exp_sync(int t, bit horiz);
        int x, y;
        bit on;
        if (t < 0) return ~SYNC_ON;
        x = t % HT;
        y = (t / HT) % VT;
        on = horiz ? (x >= HA + HF && x < HA + HF + HS)
                   : (y >= VA + VF && y < VA + VF + VS);
        return on ? SYNC_ON : ~SYNC_ON;
    endfunction

    // ---------------- scoreboard counters ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n   = 1'b0;
        scale2x = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if (pix_ce !== 1'b0) begin n_fail++; $display("FAIL reset_pix_ce got %b exp 0", pix_ce); end
        n_tests++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got %b exp 0", frame_start); end
        n_tests++; if (row_read !== 8'd0) begin n_fail++; $display("FAIL reset_row got %0d exp 0", row_read); end
        n_tests++; if (col_read !== 9'd0) begin n_fail++; $display("FAIL reset_col got %0d exp 0", col_read); end
        n_tests++; if (vga_hs !== ~SYNC_ON) begin n_fail++; $display("FAIL reset_hs got %b exp %b", vga_hs, ~SYNC_ON); end
        n_tests++; if (vga_vs !== ~SYNC_ON) begin n_fail++; $display("FAIL reset_vs got %b exp %b", vga_vs, ~SYNC_ON); end
        n_tests++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL reset_rgb got %h exp 000", {vga_r, vga_g, vga_b}); end
        rst_n = 1'b1;
    endtask

    // Sync periods and widths measured in clks from the pin edges; pix_ce and
    // frame_start checked every clk against the time base.
    task automatic test_sync_timing();
        int hs_fall[$], hs_rise[$], vs_fall[$], vs_rise[$];
        logic hs_prev, vs_prev;
        hs_prev = vga_hs;
        vs_prev = vga_vs;
        for (int k = 0; k < 1400; k++) begin
            @(negedge clk);
            n_tests++;
            if (pix_ce !== exp_pce) begin n_fail++; $display("FAIL pix_ce e=%0d got %b exp %b", e_cnt, pix_ce, exp_pce); end
            n_tests++;
            if (frame_start !== (exp_pce && (c_cnt % FT == 0))) begin
                n_fail++; $display("FAIL frame_start e=%0d got %b exp %b", e_cnt, frame_start, exp_pce && (c_cnt % FT == 0));
            end
            if (hs_prev === 1'b1 && vga_hs === 1'b0) hs_fall.push_back(e_cnt);
            if (hs_prev === 1'b0 && vga_hs === 1'b1) hs_rise.push_back(e_cnt);
            if (vs_prev === 1'b1 && vga_vs === 1'b0) vs_fall.push_back(e_cnt);
            if (vs_prev === 1'b0 && vga_vs === 1'b1) vs_rise.push_back(e_cnt);
            hs_prev = vga_hs;
            vs_prev = vga_vs;
            if (n_fail > 50) break;
        end
        n_tests++;
        if (hs_fall.size() < 2 || hs_rise.size() < 1 || vs_fall.size() < 2 || vs_rise.size() < 1) begin
            n_fail++;
            $display("FAIL sync_edges got hs_fall=%0d vs_fall=%0d exp >=2 each", hs_fall.size(), vs_fall.size());
        end else begin
            n_tests++;
            if (hs_fall[0] !== (HA + HF + 2 + L) * D) begin n_fail++; $display("FAIL hs_first_fall got %0d exp %0d", hs_fall[0], (HA + HF + 2 + L) * D); end
            n_tests++;
            if (hs_fall[1] - hs_fall[0] !== HT * D) begin n_fail++; $display("FAIL hs_period got %0d exp %0d", hs_fall[1] - hs_fall[0], HT * D); end
            n_tests++;
            if (hs_rise[0] - hs_fall[0] !== HS * D) begin n_fail++; $display("FAIL hs_low got %0d exp %0d", hs_rise[0] - hs_fall[0], HS * D); end
            n_tests++;
            if (vs_fall[0] !== ((VA + VF) * HT + 2 + L) * D) begin n_fail++; $display("FAIL vs_first_fall got %0d exp %0d", vs_fall[0], ((VA + VF) * HT + 2 + L) * D); end
            n_tests++;
            if (vs_fall[1] - vs_fall[0] !== FT * D) begin n_fail++; $display("FAIL vs_period got %0d exp %0d", vs_fall[1] - vs_fall[0], FT * D); end
            n_tests++;
            if (vs_rise[0] - vs_fall[0] !== VS * HT * D) begin n_fail++; $display("FAIL vs_low got %0d exp %0d", vs_rise[0] - vs_fall[0], VS * HT * D); end
        end
    endtask

    // policy 0: scale2x held 0; 1: scale2x raised once at a random clk;
    // 2: scale2x toggled at random clks (mostly mid-frame).
    task automatic test_window(input int policy, input int ncyc);
        int ta, to, set_at;
        logic [11:0] ec;
        set_at = $urandom_range(50, 600);
        if (policy == 0) scale2x = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            ta = c_cnt - 1;
            to = c_cnt - 2 - L;
            ec = exp_colour(to);
            n_tests++;
            if ({row_read, col_read} !== exp_addr(ta)) begin
                n_fail++;
                $display("FAIL addr t=%0d got r%0d c%0d exp r%0d c%0d", ta, row_read, col_read, exp_addr(ta) >> 9, exp_addr(ta) & 17'h1ff);
            end
            n_tests++;
            if ({vga_r, vga_g, vga_b} !== ec) begin
                n_fail++; $display("FAIL colour t=%0d got %h exp %h", to, {vga_r, vga_g, vga_b}, ec);
            end
            n_tests++;
            if ({vga_hs, vga_vs} !== {exp_sync(to, 1'b1), exp_sync(to, 1'b0)}) begin
                n_fail++; $display("FAIL sync t=%0d got %b%b exp %b%b", to, vga_hs, vga_vs, exp_sync(to, 1'b1), exp_sync(to, 1'b0));
            end
            if (policy == 1 && k == set_at) scale2x = 1'b1;
            if (policy == 2 && $urandom_range(0, 299) == 0) scale2x = ~scale2x;
            if (n_fail > 50) break;
        end
    endtask

    task automatic test_reset_midline();
        int found;
        repeat ($urandom_range(10, 40)) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (pix_ce !== 1'b0) begin n_fail++; $display("FAIL midreset_pix_ce got %b exp 0", pix_ce); end
        n_tests++; if ({row_read, col_read} !== 17'd0) begin n_fail++; $display("FAIL midreset_addr got %h exp 0", {row_read, col_read}); end
        n_tests++; if ({vga_hs, vga_vs} !== {~SYNC_ON, ~SYNC_ON}) begin n_fail++; $display("FAIL midreset_sync got %b%b exp 11", vga_hs, vga_vs); end
        n_tests++; if ({vga_r, vga_g, vga_b} !== 12'h000) begin n_fail++; $display("FAIL midreset_rgb got %h exp 000", {vga_r, vga_g, vga_b}); end
        scale2x = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        found = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (vga_hs === SYNC_ON) begin found = e_cnt; break; end
        end
        n_tests++;
        if (found !== (HA + HF + 2 + L) * D) begin
            n_fail++; $display("FAIL midreset_hs_fall got %0d exp %0d", found, (HA + HF + 2 + L) * D);
        end
    endtask

    initial begin
        scale2x = 1'b0;
        test_reset();
        test_sync_timing();
        test_window(0, 800);
        test_window(1, 1800);
        test_window(2, 2200);
        test_reset_midline();
        test_window(0, 800);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
